// File: rtl/i2s_writer.sv
// Philips I2S transmitter: pulls tagged 24-bit samples through a 4-phase
// request/ack handshake into a one-deep shadow and serialises them MSB first.
module i2s_writer #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  i2s_clock,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  audio_data_request,
  input  logic                  audio_data_ack,
  input  logic [DATA_WIDTH-1:0] audio_data,
  input  logic                  audio_lr_bit,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);
  localparam int POS_W = $clog2(2*SLOT_WIDTH);

  logic                  phase;
  logic [POS_W-1:0]      bit_pos, pos_nxt, p_nxt;
  logic                  fall, nxt_ch, slot_load, load_ok, capture;
  logic                  sh_full, sh_lr;
  logic [DATA_WIDTH-1:0] sh_data, shift_reg;

  // phase=1 this cycle means bclk falls at the coming edge
  assign fall      = phase;
  assign pos_nxt   = (bit_pos == POS_W'(2*SLOT_WIDTH-1)) ? '0 : bit_pos + 1'b1;
  assign nxt_ch    = pos_nxt >= POS_W'(SLOT_WIDTH);
  assign p_nxt     = nxt_ch ? pos_nxt - POS_W'(SLOT_WIDTH) : pos_nxt;
  assign slot_load = fall && (p_nxt == '0);
  assign load_ok   = sh_full && (sh_lr == nxt_ch);
  assign capture   = audio_data_request && audio_data_ack;
  assign i2s_bclk  = phase;
  assign i2s_lrclk = bit_pos >= POS_W'(SLOT_WIDTH);

  always_ff @(posedge i2s_clock or posedge rst) begin
    if (rst) begin
      phase              <= 1'b0;
      bit_pos            <= '0;
      audio_data_request <= 1'b0;
      sh_full            <= 1'b0;
      sh_lr              <= 1'b0;
      sh_data            <= '0;
      shift_reg          <= '0;
      i2s_sdata          <= 1'b0;
      underrun           <= 1'b0;
      underrun_count     <= '0;
    end else if (!enable) begin
      phase              <= 1'b0;
      bit_pos            <= '0;
      audio_data_request <= 1'b0;
      sh_full            <= 1'b0;
      sh_lr              <= 1'b0;
      sh_data            <= '0;
      shift_reg          <= '0;
      i2s_sdata          <= 1'b0;
      underrun           <= 1'b0;
    end else begin
      phase              <= ~phase;
      // ack must return low before the next request goes out
      audio_data_request <= ~sh_full & ~audio_data_ack;
      underrun           <= 1'b0;
      if (capture) begin
        sh_full <= 1'b1;
        sh_data <= audio_data;
        sh_lr   <= audio_lr_bit;
      end
      if (fall) begin
        bit_pos <= pos_nxt;
        if (slot_load) begin
          i2s_sdata <= 1'b0;
          if (load_ok) begin
            shift_reg <= sh_data;
            sh_full   <= 1'b0;
          end else begin
            // wrong-channel shadow is kept so it lands in its own slot next
            shift_reg <= '0;
            underrun  <= 1'b1;
            if (underrun_count != 16'hFFFF)
              underrun_count <= underrun_count + 1'b1;
          end
        end else if (p_nxt <= POS_W'(DATA_WIDTH)) begin
          i2s_sdata <= shift_reg[DATA_WIDTH-1];
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end else begin
          i2s_sdata <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_writer.sv
// Scoreboard bench for i2s_writer: a cycle-count slot model predicts each slot's
// channel, payload, underrun and count; a serial monitor rebuilds slots and compares.
module tb_i2s_writer;
  localparam int SLOT = 32;

  logic        i2s_clock = 1'b0;
  logic        rst = 1'b1, enable = 1'b0, audio_data_ack = 1'b0, audio_lr_bit = 1'b0;
  logic [23:0] audio_data = '0;
  logic        audio_data_request, i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
  logic [15:0] underrun_count;

  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic        ch;
    logic [23:0] data;
    logic        urun;
    logic [15:0] cnt;
  } slot_t;
  slot_t exp_q[$];

  i2s_writer dut (
    .i2s_clock(i2s_clock), .rst(rst), .enable(enable),
    .audio_data_request(audio_data_request), .audio_data_ack(audio_data_ack),
    .audio_data(audio_data), .audio_lr_bit(audio_lr_bit),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 i2s_clock = ~i2s_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slots are derived from the count of enabled cycles.
  int          m_j = 0, preload_seq = 0, preload_seen = 0;
  logic [15:0] preload_val = '0, m_cnt = '0;
  logic        m_full = 1'b0, m_lr = 1'b0, m_req = 1'b0;
  logic [23:0] m_data = '0;

  always @(posedge i2s_clock) begin : model
    logic full0, ch;
    int   k;
    if (rst || !enable) begin
      m_j = 0; m_full = 1'b0; m_req = 1'b0;
      exp_q.delete();
      if (rst) m_cnt = '0;
      else if (preload_seq != preload_seen) begin
        preload_seen = preload_seq;
        m_cnt = preload_val;
      end
    end else begin
      check("request", audio_data_request, m_req);
      m_j++;
      full0 = m_full;
      if (m_j % 2 == 0) begin
        k = m_j / 2;
        if (k % SLOT == 0) begin
          ch = (k % (2*SLOT)) >= SLOT;
          if (m_full && m_lr == ch) begin
            exp_q.push_back({ch, m_data, 1'b0, m_cnt});
            m_full = 1'b0;
          end else begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            exp_q.push_back({ch, 24'h0, 1'b1, m_cnt});
          end
        end
      end
      if (m_req && audio_data_ack) begin
        m_full = 1'b1; m_data = audio_data; m_lr = audio_lr_bit;
      end
      m_req = !full0 && !audio_data_ack;
    end
  end

  // Monitor: rebuilds 32-bit slots from the serial lines, starting at each lrclk edge.
  logic        mon_prev_bclk = 1'b0, mon_last_lr = 1'b0, mon_active = 1'b0;
  logic        mon_urun = 1'b0, mon_stray = 1'b0, mon_ch = 1'b0;
  logic [31:0] mon_bits = '0;
  logic [15:0] mon_cnt = '0;
  int          mon_nb = 0;

  always @(negedge i2s_clock) begin : monitor
    slot_t e;
    logic  start;
    if (rst || !enable) begin
      mon_prev_bclk = 1'b0; mon_last_lr = 1'b0; mon_active = 1'b0;
    end else begin
      start = 1'b0;
      if (mon_prev_bclk && !i2s_bclk && i2s_lrclk != mon_last_lr) begin
        start = 1'b1;
        mon_last_lr = i2s_lrclk; mon_active = 1'b1; mon_nb = 0; mon_bits = '0;
        mon_urun = underrun; mon_stray = 1'b0; mon_ch = i2s_lrclk; mon_cnt = underrun_count;
      end
      if (mon_active && underrun && !start) mon_stray = 1'b1;
      if (mon_active && mon_prev_bclk && !i2s_bclk) begin
        mon_bits = {mon_bits[30:0], i2s_sdata};
        mon_nb++;
        if (mon_nb == 2*16) begin
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL slot_queue: got a slot with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("slot_ch", mon_ch, e.ch);
            check("slot_data", mon_bits[30:7], e.data);
            check("slot_pad", {mon_bits[31], mon_bits[6:0]}, 0);
            check("slot_underrun", mon_urun, e.urun);
            check("underrun_stray", mon_stray, 0);
            check("slot_count", mon_cnt, e.cnt);
          end
        end
      end
      mon_prev_bclk = i2s_bclk;
    end
  end

  // Upstream producer: 0 idle, 1 fixed L/R pattern with 3-cycle ack, 2 random.
  int   prod_mode = 0, start_delay = 0, hold_seq = 0;
  logic start_lr = 1'b0;

  initial begin : producer
    int   t, wcnt, dly, hold_left, hold_seen;
    logic p_lr;
    t = 0; wcnt = 0; dly = 3; hold_left = 0; hold_seen = 0; p_lr = 1'b0;
    forever begin
      @(posedge i2s_clock); #2;
      if (rst || !enable || prod_mode == 0) begin
        audio_data_ack = 1'b0; p_lr = start_lr; t = 0; wcnt = 0; hold_left = 0; dly = 3;
      end else begin
        t++;
        if (t > start_delay) begin
          if (audio_data_ack) begin
            if (!audio_data_request) begin
              if (hold_left > 0) hold_left--;
              else audio_data_ack = 1'b0;
            end
          end else if (audio_data_request) begin
            if (wcnt >= dly) begin
              audio_data_ack = 1'b1;
              audio_lr_bit   = p_lr;
              if (prod_mode == 1) audio_data = p_lr ? 24'h123456 : 24'hA5A5A5;
              else                audio_data = 24'($urandom());
              p_lr = !p_lr;
              wcnt = 0;
              dly  = (prod_mode == 1) ? 3 : int'($urandom_range(0, 20));
              if (hold_seq != hold_seen) begin
                hold_seen = hold_seq;
                hold_left = 200;
              end
            end else wcnt++;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge i2s_clock);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] cnt);
    check({tag, "_req"}, audio_data_request, 0);
    check({tag, "_bclk"}, i2s_bclk, 0);
    check({tag, "_lrclk"}, i2s_lrclk, 0);
    check({tag, "_sdata"}, i2s_sdata, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_count"}, underrun_count, cnt);
  endtask

  task automatic restart();
    enable = 1'b0;
    check("slots_drained", exp_q.size() <= 1, 1);
    cycles(3);
    enable = 1'b1;
  endtask

  initial begin : main
    cycles(3);
    chk_idle("reset", 16'h0);
    rst = 1'b0;
    cycles(2);
    chk_idle("idle_disabled", 16'h0);

    // starvation: every slot after the first is an underrun
    enable = 1'b1;
    cycles(1);
    check("req_after_enable", audio_data_request, 1);
    cycles(255);
    check("count_2frames", underrun_count, 16'd4);

    // ping-pong pattern: only the first right slot starves
    prod_mode = 1; start_lr = 1'b0; start_delay = 0;
    restart();
    cycles(4*128);
    check("pingpong_count", underrun_count, 16'd5);

    // random samples and handshake delays
    prod_mode = 2;
    cycles(20*128);
    check("random_count", underrun_count, m_cnt);

    // ack held high after a capture
    hold_seq++;
    cycles(8*128);
    check("hold_count", underrun_count, m_cnt);

    // first sample tagged right, offered during the right slot
    prod_mode = 1; start_lr = 1'b1; start_delay = 70;
    restart();
    cycles(5*128);
    check("misalign_count", underrun_count, m_cnt);

    // async reset at left slot p=10
    start_lr = 1'b0; start_delay = 0;
    restart();
    cycles(148);
    check("pre_rst_lrclk", i2s_lrclk, 0);
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 16'h0);
    @(posedge i2s_clock); #1;
    rst = 1'b0;
    cycles(63);
    check("frame_restart_left", i2s_lrclk, 0);
    cycles(1);
    check("frame_restart_right", i2s_lrclk, 1);
    cycles(3*128 + 37);

    // drop enable mid-slot
    enable = 1'b0;
    cycles(1);
    chk_idle("disable", m_cnt);
    cycles(10);
    check("count_held", underrun_count, m_cnt);

    // saturation from a preloaded count
    prod_mode = 0;
    force dut.underrun_count = 16'hFFFD;
    preload_val = 16'hFFFD; preload_seq++;
    cycles(2);
    release dut.underrun_count;
    cycles(1);
    check("preload_count", underrun_count, 16'hFFFD);
    enable = 1'b1;
    cycles(2*128 + 4);
    check("count_saturated", underrun_count, 16'hFFFF);
    check("slots_drained_end", exp_q.size() <= 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
